// File: rtl/bootrom_loader.sv
// Byte-stream loader for the boot/program RAM: assembles big-endian words,
// writes them to consecutive addresses, then reads back and compares sums.
module bootrom_loader #(
    parameter int DATA = 32,
    parameter int ADDR = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR-1:0]   base_addr,
    input  logic [ADDR:0]     word_count,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR-1:0]   mem_addr,
    output logic [DATA-1:0]   mem_wdata,
    input  logic [DATA-1:0]   mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA-1:0]   checksum
);

    localparam int BYTES = DATA / 8;
    localparam int BCW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);
    localparam logic [ADDR:0] CONE = 1;
    localparam logic [ADDR-1:0] AONE = 1;

    typedef enum logic [2:0] {
        IDLE, FILL, WRITE, VRD, VCHK, FIN
    } state_t;

    state_t            state;
    logic [ADDR-1:0]   base_q;
    logic [ADDR-1:0]   addr_q;
    logic [ADDR:0]     count_q;
    logic [ADDR:0]     remain_q;
    logic [ADDR:0]     rd_cnt;
    logic [BCW-1:0]    byte_cnt;
    logic [DATA-1:0]   word_q;
    logic [DATA-1:0]   wsum;
    logic [DATA-1:0]   rsum;
    logic [DATA-1:0]   word_next;
    logic [DATA-1:0]   rsum_final;

    // New byte enters at the bottom, so the first byte ends up in the MSBs.
    assign word_next  = DATA'({word_q, s_data});
    assign rsum_final = rsum + mem_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            s_ready   <= 1'b0;
            mem_ce    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            checksum  <= '0;
            base_q    <= '0;
            addr_q    <= '0;
            count_q   <= '0;
            remain_q  <= '0;
            rd_cnt    <= '0;
            byte_cnt  <= '0;
            word_q    <= '0;
            wsum      <= '0;
            rsum      <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        base_q   <= base_addr;
                        addr_q   <= base_addr;
                        count_q  <= word_count;
                        remain_q <= word_count;
                        wsum     <= '0;
                        rsum     <= '0;
                        err      <= 1'b0;
                        byte_cnt <= '0;
                        word_q   <= '0;
                        if (word_count == '0) begin
                            checksum <= '0;
                            done     <= 1'b1;
                            state    <= FIN;
                        end else begin
                            busy    <= 1'b1;
                            s_ready <= 1'b1;
                            state   <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (s_valid && s_ready) begin
                        word_q <= word_next;
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt  <= '0;
                            s_ready   <= 1'b0;
                            mem_ce    <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= addr_q;
                            mem_wdata <= word_next;
                            state     <= WRITE;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    wsum     <= wsum + mem_wdata;
                    mem_we   <= 1'b0;
                    remain_q <= remain_q - CONE;
                    if (remain_q != CONE) begin
                        addr_q  <= addr_q + AONE;
                        mem_ce  <= 1'b0;
                        s_ready <= 1'b1;
                        state   <= FILL;
                    end else begin
                        addr_q   <= base_q;
                        mem_addr <= base_q;
                        rd_cnt   <= CONE;
                        state    <= VRD;
                    end
                end
                VRD: begin
                    // Read data lags its address by one cycle.
                    if (rd_cnt != CONE) begin
                        rsum <= rsum + mem_rdata;
                    end
                    if (rd_cnt == count_q) begin
                        mem_ce <= 1'b0;
                        state  <= VCHK;
                    end else begin
                        mem_addr <= mem_addr + AONE;
                        rd_cnt   <= rd_cnt + CONE;
                    end
                end
                VCHK: begin
                    rsum     <= rsum_final;
                    err      <= (rsum_final != wsum);
                    checksum <= wsum;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= FIN;
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bootrom_loader.sv
// Directed bench for bootrom_loader with a registered-read RAM model.
module tb_bootrom_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] base_addr;
    logic [12:0] word_count;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        mem_ce;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] checksum;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int ce_cnt = 0;
    int wr_n = 0;
    int rd_n = 0;
    int t0;
    int t1;
    int wb;
    int rb;
    int dc;
    int cc;
    int hits;

    logic [11:0] wr_addr [0:255];
    logic [31:0] wr_data [0:255];
    logic [11:0] rd_addr [0:255];
    logic [31:0] ram [0:4095];
    logic        corrupt_en = 1'b0;
    logic [11:0] corrupt_addr = 12'h0;

    bootrom_loader #(.DATA(32), .ADDR(12)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .base_addr(base_addr), .word_count(word_count),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .err(err), .checksum(checksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (mem_ce) ce_cnt <= ce_cnt + 1;
        if (mem_ce && mem_we) begin
            ram[mem_addr]  <= mem_wdata;
            wr_addr[wr_n]  <= mem_addr;
            wr_data[wr_n]  <= mem_wdata;
            wr_n           <= wr_n + 1;
        end
        if (mem_ce && !mem_we) begin
            mem_rdata <= ram[mem_addr] ^
                ((corrupt_en && mem_addr == corrupt_addr) ? 32'h1 : 32'h0);
            rd_addr[rd_n] <= mem_addr;
            rd_n          <= rd_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [11:0] b, input logic [12:0] n);
        base_addr  = b;
        word_count = n;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0    = cyc;
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        bit acc;
        if (gap) begin
            repeat ($urandom_range(0, 2)) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
        end
        s_data  = b;
        s_valid = 1'b1;
        acc     = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(posedge clk);
            acc = s_ready;
            @(negedge clk);
        end
        s_valid = 1'b0;
        if (!acc) chk("byte_accept_timeout", 0, 1);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        send(w[31:24], gap);
        send(w[23:16], gap);
        send(w[15:8], gap);
        send(w[7:0], gap);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && !done; i++) @(negedge clk);
        t1 = cyc;
        chk("done_seen", done, 1);
    endtask

    task automatic mark();
        wb = wr_n;
        rb = rd_n;
        dc = done_cnt;
        cc = ce_cnt;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; s_valid = 1'b0;
        s_data = 8'h0; base_addr = 12'h0; word_count = 13'h0;
        repeat (2) @(negedge clk);
        chk("reset_ctrl", {s_ready, mem_ce, mem_we, busy, done, err}, 0);
        chk("reset_addr", mem_addr, 0);
        chk("reset_wdata", mem_wdata, 0);
        chk("reset_csum", checksum, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: two words, contiguous stream
        mark();
        do_start(12'h010, 13'd2);
        chk("t1_busy", busy, 1);
        send_word(32'h12345678, 1'b0);
        send_word(32'hAABBCCDD, 1'b0);
        wait_done();
        chk("t1_latency", t1 - t0, 13);
        chk("t1_csum", checksum, 32'hBCF02355);
        chk("t1_err", err, 0);
        chk("t1_busy_fin", busy, 0);
        repeat (3) @(negedge clk);
        chk("t1_done_pulses", done_cnt - dc, 1);
        chk("t1_nwr", wr_n - wb, 2);
        chk("t1_wr0", {wr_addr[wb], wr_data[wb]}, {12'h010, 32'h12345678});
        chk("t1_wr1", {wr_addr[wb+1], wr_data[wb+1]}, {12'h011, 32'hAABBCCDD});
        chk("t1_nrd", rd_n - rb, 2);
        chk("t1_rd", {rd_addr[rb], rd_addr[rb+1]}, {12'h010, 12'h011});

        // 2: zero-length load
        mark();
        do_start(12'h020, 13'd0);
        wait_done();
        chk("t2_latency", t1 - t0, 0);
        chk("t2_csum", checksum, 0);
        chk("t2_err", err, 0);
        repeat (3) @(negedge clk);
        chk("t2_no_ce", ce_cnt - cc, 0);
        chk("t2_done_pulses", done_cnt - dc, 1);

        // 3: address wrap
        mark();
        do_start(12'hFFF, 13'd2);
        send_word(32'h01020304, 1'b0);
        send_word(32'h10203040, 1'b0);
        wait_done();
        chk("t3_csum", checksum, 32'h11223344);
        chk("t3_err", err, 0);
        @(negedge clk);
        chk("t3_wr0", {wr_addr[wb], wr_data[wb]}, {12'hFFF, 32'h01020304});
        chk("t3_wr1", {wr_addr[wb+1], wr_data[wb+1]}, {12'h000, 32'h10203040});
        chk("t3_rd", {rd_addr[rb], rd_addr[rb+1]}, {12'hFFF, 12'h000});

        // 4: corrupted readback sets err
        corrupt_en   = 1'b1;
        corrupt_addr = 12'h100;
        do_start(12'h100, 13'd1);
        send_word(32'hDEADBEEF, 1'b0);
        wait_done();
        chk("t4_err", err, 1);
        chk("t4_csum", checksum, 32'hDEADBEEF);
        repeat (2) @(negedge clk);
        chk("t4_err_sticky", err, 1);
        corrupt_en = 1'b0;

        // 5: gapped stream, spurious start while busy
        mark();
        do_start(12'h200, 13'd2);
        chk("t5_err_clr", err, 0);
        send_word(32'h12345678, 1'b1);
        base_addr  = 12'h7AA;
        word_count = 13'd5;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t5_busy_kept", busy, 1);
        send_word(32'hAABBCCDD, 1'b1);
        wait_done();
        chk("t5_csum", checksum, 32'hBCF02355);
        chk("t5_err", err, 0);
        repeat (3) @(negedge clk);
        chk("t5_nwr", wr_n - wb, 2);
        chk("t5_wr0", {wr_addr[wb], wr_data[wb]}, {12'h200, 32'h12345678});
        chk("t5_wr1", {wr_addr[wb+1], wr_data[wb+1]}, {12'h201, 32'hAABBCCDD});
        chk("t5_idle", busy, 0);

        // 6: reset in the middle of the second word
        mark();
        do_start(12'h300, 13'd3);
        send_word(32'h11111111, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_ctrl", {s_ready, mem_ce, mem_we, busy, done, err}, 0);
        chk("t6_rst_addr", mem_addr, 0);
        chk("t6_rst_wdata", mem_wdata, 0);
        chk("t6_rst_csum", checksum, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        hits = 0;
        for (int i = wb; i < wr_n; i++) if (wr_addr[i] == 12'h301) hits++;
        chk("t6_no_wr301", hits, 0);
        chk("t6_nwr", wr_n - wb, 1);
        mark();
        do_start(12'h300, 13'd1);
        send_word(32'hCAFEBABE, 1'b0);
        wait_done();
        chk("t6_csum", checksum, 32'hCAFEBABE);
        chk("t6_err", err, 0);
        @(negedge clk);
        chk("t6_wr", {wr_addr[wb], wr_data[wb]}, {12'h300, 32'hCAFEBABE});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
